// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, multi-cycle divide, EXE redirects.
module hazard_controller #(
    parameter int unsigned DIV_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rsA,
    input  logic [4:0]       id_rsB,
    input  logic             id_use_A,
    input  logic             id_use_B,
    input  logic [4:0]       exe_rd,
    input  logic             exe_wr_en,
    input  logic             exe_is_load,
    input  logic             exe_is_div,
    input  logic             exe_redirect,
    input  logic             div_done,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_exe,
    output logic             bubble_exe,
    output logic             flush_ifid,
    output logic             div_start,
    output logic             div_busy,
    output logic             div_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned DIV_CNT_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_TIMEOUT - 1);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_DIV_WAIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic                 div_timeout_q, div_timeout_d;
    logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;
    logic                 load_use_c;

    // ID consumes a register that the load in EXE has not produced yet
    always_comb begin
        load_use_c = exe_is_load & exe_wr_en & (exe_rd != 5'd0) &
                     ((id_use_A & (id_rsA == exe_rd)) | (id_use_B & (id_rsB == exe_rd)));
    end

    // Next-state and same-cycle pipeline controls; everything forced low during reset
    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        div_timeout_d = div_timeout_q;
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        stall_exe     = 1'b0;
        bubble_exe    = 1'b0;
        flush_ifid    = 1'b0;
        div_start     = 1'b0;
        div_busy      = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (exe_redirect) begin
                        // ID holds a wrong-path instruction, so its hazards do not matter
                        flush_ifid = 1'b1;
                        bubble_exe = 1'b1;
                    end else if (exe_is_div) begin
                        div_start = 1'b1;
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_exe = 1'b1;
                        state_d   = ST_DIV_WAIT;
                        div_cnt_d = '0;
                    end else if (load_use_c) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        bubble_exe = 1'b1;
                    end
                end
                ST_DIV_WAIT: begin
                    div_busy = 1'b1;
                    if (div_done) begin
                        // Release: EXE/MEM captures the quotient at this edge
                        state_d = ST_RUN;
                    end else if (div_cnt_q == DIV_LAST) begin
                        div_timeout_d = 1'b1;
                        state_d       = ST_RUN;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_exe = 1'b1;
                        div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_if && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // State and counter registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            div_cnt_q      <= '0;
            div_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            div_cnt_q      <= div_cnt_d;
            div_timeout_q  <= div_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign div_timeout  = div_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table plus multi-cycle divide/reset sequences.
module tb_hazard_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rsA, id_rsB, exe_rd;
    logic        id_use_A, id_use_B, exe_wr_en, exe_is_load, exe_is_div, exe_redirect, div_done;
    logic        stall_if, stall_id, stall_exe, bubble_exe, flush_ifid, div_start, div_busy, div_timeout;
    logic [31:0] stall_cycles;
    logic        s4_if, s4_id, s4_exe, s4_bub, s4_fl, s4_ds, s4_busy, s4_to;
    logic [3:0]  stall_cycles4;

    int total = 0;
    int bad   = 0;
    int starts = 0;

    hazard_controller #(.DIV_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_rsA(id_rsA), .id_rsB(id_rsB), .id_use_A(id_use_A), .id_use_B(id_use_B),
        .exe_rd(exe_rd), .exe_wr_en(exe_wr_en), .exe_is_load(exe_is_load), .exe_is_div(exe_is_div),
        .exe_redirect(exe_redirect), .div_done(div_done), .stall_if(stall_if), .stall_id(stall_id),
        .stall_exe(stall_exe), .bubble_exe(bubble_exe), .flush_ifid(flush_ifid), .div_start(div_start),
        .div_busy(div_busy), .div_timeout(div_timeout), .stall_cycles(stall_cycles)
    );

    hazard_controller #(.DIV_TIMEOUT(64), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_rsA(id_rsA), .id_rsB(id_rsB), .id_use_A(id_use_A), .id_use_B(id_use_B),
        .exe_rd(exe_rd), .exe_wr_en(exe_wr_en), .exe_is_load(exe_is_load), .exe_is_div(exe_is_div),
        .exe_redirect(exe_redirect), .div_done(div_done), .stall_if(s4_if), .stall_id(s4_id),
        .stall_exe(s4_exe), .bubble_exe(s4_bub), .flush_ifid(s4_fl), .div_start(s4_ds),
        .div_busy(s4_busy), .div_timeout(s4_to), .stall_cycles(stall_cycles4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    always @(negedge clk) if (!rst && div_start) starts++;

    // Expected {div_busy, stall_if, stall_id, stall_exe, bubble_exe, flush_ifid, div_start}
    typedef struct {
        string      name;
        logic [6:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [4:0] rsA;
        logic [4:0] rsB;
        logic       useA;
        logic       useB;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       redir;
        logic [5:0] ctl;
    } vec_t;

    localparam logic [6:0] E_IDLE  = 7'b0_000000;
    localparam logic [6:0] E_LU    = 7'b0_110100;
    localparam logic [6:0] E_REDIR = 7'b0_000110;
    localparam logic [6:0] E_START = 7'b0_111001;
    localparam logic [6:0] E_WAIT  = 7'b1_111000;
    localparam logic [6:0] E_REL   = 7'b1_000000;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, want, $time);
        end
    endtask

    // One clock: queue the expectation, compare mid-cycle, advance past the next rising edge
    task automatic step(input string nm, input logic [6:0] e);
        sb_t s;
        sb_q.push_back('{nm, e});
        @(negedge clk);
        s = sb_q.pop_front();
        check(s.name, 32'({div_busy, stall_if, stall_id, stall_exe, bubble_exe, flush_ifid, div_start}),
              32'(s.exp));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rsA = 5'd0; id_rsB = 5'd0; id_use_A = 1'b0; id_use_B = 1'b0;
        exe_rd = 5'd0; exe_wr_en = 1'b0; exe_is_load = 1'b0; exe_is_div = 1'b0;
        exe_redirect = 1'b0; div_done = 1'b0;
    endtask

    initial begin
        vec_t vecs[10];
        int   exp_stalls;
        logic [31:0] sc0;

        // rsA rsB useA useB rd wr ld redir ctl
        vecs[0] = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 6'b110100}; // JALR on load dest
        vecs[1] = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 1'b0, 6'b000000}; // x0 never hazards
        vecs[2] = '{5'd9,  5'd0,  1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 6'b000000}; // match, not used in ID
        vecs[3] = '{5'd1,  5'd12, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 6'b110100}; // branch rsB match
        vecs[4] = '{5'd7,  5'd0,  1'b1, 1'b0, 5'd7,  1'b0, 1'b1, 1'b0, 6'b000000}; // load without write
        vecs[5] = '{5'd7,  5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 6'b000000}; // ALU op, forwarded
        vecs[6] = '{5'd3,  5'd0,  1'b1, 1'b0, 5'd3,  1'b1, 1'b1, 1'b1, 6'b000110}; // redirect beats load-use
        vecs[7] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 6'b000110}; // plain redirect
        vecs[8] = '{5'd30, 5'd31, 1'b1, 1'b1, 5'd29, 1'b1, 1'b1, 1'b0, 6'b000000}; // no register match
        vecs[9] = '{5'd31, 5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 6'b110100}; // x31 on rsB

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset: controls low while rst held, even with hazards presented
        exe_is_div = 1'b1;
        step("rst_ctl", E_IDLE);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        check("rst_div_timeout", 32'(div_timeout), 32'd0);
        idle_inputs();
        rst = 1'b0;

        // Load-use: one stall cycle, then the load has moved to MEM
        exe_rd = 5'd5; exe_wr_en = 1'b1; exe_is_load = 1'b1; id_rsA = 5'd5; id_use_A = 1'b1;
        step("t1_load_use", E_LU);
        exe_is_load = 1'b0;
        step("t1_release", E_IDLE);
        check("t1_stall_cycles", stall_cycles, 32'd1);

        // Single-cycle vector table
        exp_stalls = 1;
        for (int i = 0; i < 10; i++) begin
            id_rsA = vecs[i].rsA; id_rsB = vecs[i].rsB; id_use_A = vecs[i].useA; id_use_B = vecs[i].useB;
            exe_rd = vecs[i].rd; exe_wr_en = vecs[i].wr; exe_is_load = vecs[i].ld;
            exe_redirect = vecs[i].redir; exe_is_div = 1'b0; div_done = 1'b0;
            if (vecs[i].ctl[5]) exp_stalls++;
            step($sformatf("vec%0d", i), {1'b0, vecs[i].ctl});
        end
        check("vec_stall_cycles", stall_cycles, 32'(exp_stalls));

        // div_done outside a divide is ignored
        idle_inputs();
        div_done = 1'b1;
        step("run_div_done", E_IDLE);

        // Divide answered on the 33rd cycle after start
        idle_inputs();
        sc0 = stall_cycles;
        exe_is_div = 1'b1; exe_rd = 5'd8; exe_wr_en = 1'b1;
        step("t3_start", E_START);
        exe_redirect = 1'b1; exe_is_load = 1'b1; id_rsA = 5'd8; id_use_A = 1'b1;
        for (int i = 1; i <= 32; i++) step($sformatf("t3_wait%0d", i), E_WAIT);
        exe_redirect = 1'b0; exe_is_load = 1'b0; id_use_A = 1'b0;
        div_done = 1'b1;
        step("t3_done", E_REL);
        div_done = 1'b0; exe_is_div = 1'b0;
        step("t3_run", E_IDLE);
        check("t3_stall_delta", stall_cycles - sc0, 32'd33);
        check("t3_start_pulses", 32'(starts), 32'd1);
        check("t3_no_timeout", 32'(div_timeout), 32'd0);

        // Divider never answers: abort on the 64th wait cycle
        exe_is_div = 1'b1;
        step("t4_start", E_START);
        for (int i = 1; i <= 63; i++) step($sformatf("t4_wait%0d", i), E_WAIT);
        check("t4_pre_timeout", 32'(div_timeout), 32'd0);
        exe_is_div = 1'b0;
        step("t4_abort", E_REL);
        check("t4_timeout_set", 32'(div_timeout), 32'd1);
        step("t4_run", E_IDLE);
        step("t4_run2", E_IDLE);
        check("t4_timeout_sticky", 32'(div_timeout), 32'd1);

        // Reset in the middle of a divide
        exe_is_div = 1'b1;
        step("t6_start", E_START);
        repeat (5) step("t6_wait", E_WAIT);
        rst = 1'b1;
        step("t6_rst", E_IDLE);
        rst = 1'b0;
        check("t6_stall_cycles", stall_cycles, 32'd0);
        check("t6_timeout_clear", 32'(div_timeout), 32'd0);
        check("t6_cnt4_clear", 32'(stall_cycles4), 32'd0);
        exe_is_div = 1'b0;
        step("t6_after", E_IDLE);

        // Twenty stall cycles: narrow counter saturates
        exe_rd = 5'd4; exe_wr_en = 1'b1; exe_is_load = 1'b1; id_rsB = 5'd4; id_use_B = 1'b1;
        repeat (20) step("t6_lu", E_LU);
        idle_inputs();
        step("t6_idle", E_IDLE);
        check("t6_cnt32", stall_cycles, 32'd20);
        check("t6_cnt4_sat", 32'(stall_cycles4), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
